// File: rtl/io_mmio_ctrl.sv
// Memory-mapped IO block: UART RX/TX byte FIFOs, cycle and retired-instruction counters.
// Loads are registered (data one cycle after re). All state resets synchronously on rst.

module io_mmio_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [7:0]               wdata_i,
    output logic [7:0]               head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Pointers wrap naturally; count is kept separately so full and empty are unambiguous.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_i) wr_d = wr_q + AW'(1);
        if (pop_i)  rd_d = rd_q + AW'(1);
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_i) mem_q[wr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
endmodule

module io_mmio_ctrl #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    input  logic        instr_retire,
    output logic [31:0] rdata,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [2:0] OFF_STATUS = 3'd0;
    localparam logic [2:0] OFF_RXDATA = 3'd1;
    localparam logic [2:0] OFF_TXDATA = 3'd2;
    localparam logic [2:0] OFF_CYCLE  = 3'd4;
    localparam logic [2:0] OFF_INSTR  = 3'd5;
    localparam logic [2:0] OFF_CNTCLR = 3'd6;
    localparam logic [2:0] OFF_FSTAT  = 3'd7;

    logic             sel, rd_en, wr_en;
    logic [2:0]       off;
    logic             live_q;

    logic             rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]       rx_head;
    logic [CW-1:0]    rx_count;
    logic             tx_push, tx_pop, tx_full, tx_empty, tx_wr;
    logic [7:0]       tx_head;
    logic [CW-1:0]    tx_count;

    logic             rx_empty_rd_q, rx_empty_rd_d;
    logic             tx_ovf_q, tx_ovf_d;
    logic             sticky_clr, cnt_clr;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ins_q, ins_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [31:0]      status_word, fstat_word;
    logic [7:0]       rx_cnt8;
    logic [5:0]       tx_cnt6;
    logic             unused_bits;

    assign sel   = (addr[31:30] == 2'b10);
    assign rd_en = sel & re;
    assign wr_en = sel & we;
    assign off   = addr[4:2];

    // Handshakes stay quiet during reset and for the first cycle after it.
    always_ff @(posedge clk) begin
        if (rst) live_q <= 1'b0;
        else     live_q <= 1'b1;
    end

    assign rx_ready = live_q & ~rst & ~rx_full;
    assign tx_valid = live_q & ~rst & ~tx_empty;
    assign tx_data  = tx_head;

    // RX pop looks at the pre-push occupancy, so an empty FIFO is never popped.
    assign rx_push = rx_valid & rx_ready;
    assign rx_pop  = rd_en & (off == OFF_RXDATA) & ~rx_empty;

    // A full TX FIFO still accepts a byte when the head leaves in the same cycle.
    assign tx_pop  = tx_valid & tx_ready;
    assign tx_wr   = wr_en & (off == OFF_TXDATA);
    assign tx_push = tx_wr & (~tx_full | tx_pop);

    assign sticky_clr = wr_en & (off == OFF_FSTAT);
    assign cnt_clr    = wr_en & (off == OFF_CNTCLR);

    io_mmio_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rx_push),
        .pop_i   (rx_pop),
        .wdata_i (rx_data),
        .head_o  (rx_head),
        .count_o (rx_count),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    io_mmio_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tx_push),
        .pop_i   (tx_pop),
        .wdata_i (wdata[7:0]),
        .head_o  (tx_head),
        .count_o (tx_count),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    assign rx_cnt8     = 8'(rx_count);
    assign tx_cnt6     = 6'(tx_count);
    assign status_word = {30'b0, ~rx_empty, ~tx_full};
    assign fstat_word  = {16'b0, rx_cnt8, tx_cnt6, tx_ovf_q, rx_empty_rd_q};

    always_comb begin
        rx_empty_rd_d = rx_empty_rd_q;
        tx_ovf_d      = tx_ovf_q;
        if (sticky_clr) begin
            rx_empty_rd_d = 1'b0;
            tx_ovf_d      = 1'b0;
        end
        if (rd_en && (off == OFF_RXDATA) && rx_empty) rx_empty_rd_d = 1'b1;
        if (tx_wr && tx_full && !tx_pop)              tx_ovf_d      = 1'b1;
    end

    // Counter clear wins over the increment in the same cycle.
    always_comb begin
        cyc_d = cyc_q + CNT_W'(1);
        ins_d = instr_retire ? ins_q + CNT_W'(1) : ins_q;
        if (cnt_clr) begin
            cyc_d = '0;
            ins_d = '0;
        end
    end

    // Load data reflects state before this cycle's updates; held until the next selected load.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            case (off)
                OFF_STATUS: rdata_d = status_word;
                OFF_RXDATA: rdata_d = rx_empty ? 32'h0 : {24'b0, rx_head};
                OFF_CYCLE:  rdata_d = 32'(cyc_q);
                OFF_INSTR:  rdata_d = 32'(ins_q);
                OFF_FSTAT:  rdata_d = fstat_word;
                default:    rdata_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_empty_rd_q <= 1'b0;
            tx_ovf_q      <= 1'b0;
            cyc_q         <= '0;
            ins_q         <= '0;
            rdata_q       <= '0;
        end else begin
            rx_empty_rd_q <= rx_empty_rd_d;
            tx_ovf_q      <= tx_ovf_d;
            cyc_q         <= cyc_d;
            ins_q         <= ins_d;
            rdata_q       <= rdata_d;
        end
    end

    assign rdata = rdata_q;

    assign unused_bits = ^{addr[29:5], addr[1:0], wdata[31:8]};
endmodule

// File: tb/tb_io_mmio_ctrl.sv
// Directed bench for io_mmio_ctrl: FIFO data paths, sticky flags, counters and reset.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_io_mmio_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic        instr_retire;
    logic [31:0] rdata;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int n_checks = 0;
    int n_fail   = 0;

    io_mmio_ctrl #(.FIFO_DEPTH(8), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .wdata        (wdata),
        .we           (we),
        .re           (re),
        .instr_retire (instr_retire),
        .rdata        (rdata),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic bus_rd(input logic [31:0] a);
        addr = a; re = 1'b1;
        @(negedge clk);
        re = 1'b0; addr = 32'h0;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0; addr = 32'h0;
    endtask

    task automatic rx_send(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rst_rx_ready: got %b want 0", rx_ready); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", rdata); end
        rst = 1'b0;
        #1;
        n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL post_rst_rx_ready: got %b want 0", rx_ready); end
        @(negedge clk);
        n_checks++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL live_rx_ready: got %b want 1", rx_ready); end
        bus_rd(32'h8000_0000);
        n_checks++; if (rdata !== 32'h1) begin n_fail++; $display("FAIL rst_status: got %h want 1", rdata); end
        bus_rd(32'h8000_001C);
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rst_fstat: got %h want 0", rdata); end
    endtask

    task automatic test_rx_basic;
        rx_send(8'h41);
        rx_send(8'h42);
        bus_rd(32'h8000_0004);
        n_checks++; if (rdata !== 32'h41) begin n_fail++; $display("FAIL rx_pop0: got %h want 41", rdata); end
        @(negedge clk);
        n_checks++; if (rdata !== 32'h41) begin n_fail++; $display("FAIL rdata_hold: got %h want 41", rdata); end
        bus_rd(32'h8000_0004);
        n_checks++; if (rdata !== 32'h42) begin n_fail++; $display("FAIL rx_pop1: got %h want 42", rdata); end
        bus_rd(32'h8000_0000);
        n_checks++; if (rdata !== 32'h1) begin n_fail++; $display("FAIL rx_drained_status: got %h want 1", rdata); end
    endtask

    task automatic test_rx_empty_read;
        bus_rd(32'h8000_0004);
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL empty_pop: got %h want 0", rdata); end
        bus_rd(32'h8000_001C);
        n_checks++; if (rdata !== 32'h1) begin n_fail++; $display("FAIL empty_sticky: got %h want 1", rdata); end
        bus_wr(32'h8000_001C, 32'h0);
        bus_rd(32'h8000_001C);
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL sticky_clear: got %h want 0", rdata); end
        // Pop and push on an empty FIFO in one cycle: read sees empty, byte is kept.
        rx_data = 8'h55; rx_valid = 1'b1; addr = 32'h8000_0004; re = 1'b1;
        @(negedge clk);
        re = 1'b0; rx_valid = 1'b0; addr = 32'h0;
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL race_pop: got %h want 0", rdata); end
        bus_rd(32'h8000_001C);
        n_checks++; if (rdata !== 32'h101) begin n_fail++; $display("FAIL race_fstat: got %h want 101", rdata); end
        bus_wr(32'h8000_001C, 32'hFFFF_FFFF);
        bus_rd(32'h8000_0004);
        n_checks++; if (rdata !== 32'h55) begin n_fail++; $display("FAIL race_byte: got %h want 55", rdata); end
        bus_rd(32'h8000_001C);
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL race_after: got %h want 0", rdata); end
    endtask

    task automatic test_tx_overflow;
        logic [7:0] eb;
        int got;
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) bus_wr(32'h8000_0008, 32'hA0 + 32'(i));
        bus_rd(32'h8000_0000);
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL tx_full_status: got %h want 0", rdata); end
        bus_rd(32'h8000_001C);
        n_checks++; if (rdata !== 32'h22) begin n_fail++; $display("FAIL tx_ovf_fstat: got %h want 22", rdata); end
        eb = 8'hA0; got = 0;
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (tx_valid) begin
                n_checks++; if (tx_data !== eb) begin n_fail++; $display("FAIL tx_order: got %h want %h", tx_data, eb); end
                eb = eb + 8'h1; got++;
            end
            @(negedge clk);
        end
        tx_ready = 1'b0;
        n_checks++; if (got !== 8) begin n_fail++; $display("FAIL tx_emitted: got %0d want 8", got); end
        bus_wr(32'h8000_001C, 32'h0);
        bus_rd(32'h8000_001C);
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL tx_ovf_clear: got %h want 0", rdata); end
    endtask

    task automatic test_tx_full_push_pop;
        logic [7:0] eb;
        int got;
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) bus_wr(32'h8000_0008, 32'h10 + 32'(i));
        tx_ready = 1'b1; addr = 32'h8000_0008; wdata = 32'h18; we = 1'b1;
        @(negedge clk);
        we = 1'b0; tx_ready = 1'b0; addr = 32'h0;
        bus_rd(32'h8000_001C);
        n_checks++; if (rdata !== 32'h20) begin n_fail++; $display("FAIL tx_fullpp_fstat: got %h want 20", rdata); end
        eb = 8'h11; got = 0;
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (tx_valid) begin
                n_checks++; if (tx_data !== eb) begin n_fail++; $display("FAIL tx_fullpp_order: got %h want %h", tx_data, eb); end
                eb = eb + 8'h1; got++;
            end
            @(negedge clk);
        end
        tx_ready = 1'b0;
        n_checks++; if (got !== 8) begin n_fail++; $display("FAIL tx_fullpp_count: got %0d want 8", got); end
    endtask

    task automatic test_rx_full;
        for (int i = 0; i < 8; i++) rx_send(8'h60 + 8'(i));
        n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_full_ready: got %b want 0", rx_ready); end
        bus_rd(32'h8000_001C);
        n_checks++; if (rdata !== 32'h800) begin n_fail++; $display("FAIL rx_full_fstat: got %h want 800", rdata); end
        rx_data = 8'h68; rx_valid = 1'b1;
        bus_rd(32'h8000_0004);
        n_checks++; if (rdata !== 32'h60) begin n_fail++; $display("FAIL rx_full_pop: got %h want 60", rdata); end
        @(negedge clk);
        rx_valid = 1'b0;
        n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_refill_ready: got %b want 0", rx_ready); end
        bus_rd(32'h8000_001C);
        n_checks++; if (rdata !== 32'h800) begin n_fail++; $display("FAIL rx_refill_fstat: got %h want 800", rdata); end
        for (int i = 0; i < 8; i++) begin
            bus_rd(32'h8000_0004);
            n_checks++; if (rdata !== 32'h61 + 32'(i)) begin n_fail++; $display("FAIL rx_full_order: got %h want %h", rdata, 32'h61 + 32'(i)); end
        end
    endtask

    task automatic test_read_write_same;
        bus_rd(32'h8000_0004);
        addr = 32'h8000_001C; re = 1'b1; we = 1'b1;
        @(negedge clk);
        re = 1'b0; we = 1'b0; addr = 32'h0;
        n_checks++; if (rdata !== 32'h1) begin n_fail++; $display("FAIL rw_pre_value: got %h want 1", rdata); end
        bus_rd(32'h8000_001C);
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rw_cleared: got %h want 0", rdata); end
    endtask

    task automatic test_unselected;
        rx_send(8'h77);
        bus_rd(32'h8000_0000);
        n_checks++; if (rdata !== 32'h3) begin n_fail++; $display("FAIL unsel_status: got %h want 3", rdata); end
        bus_rd(32'h0000_0004);
        n_checks++; if (rdata !== 32'h3) begin n_fail++; $display("FAIL unsel_read_hold: got %h want 3", rdata); end
        bus_wr(32'h4000_0008, 32'h99);
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL unsel_tx_push: got %b want 0", tx_valid); end
        bus_wr(32'h8000_0000, 32'hFF);
        bus_wr(32'h8000_000C, 32'h12);
        bus_rd(32'h8000_000C);
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h want 0", rdata); end
        bus_rd(32'h8000_0004);
        n_checks++; if (rdata !== 32'h77) begin n_fail++; $display("FAIL unsel_no_pop: got %h want 77", rdata); end
        bus_rd(32'hC000_0004);
        n_checks++; if (rdata !== 32'h77) begin n_fail++; $display("FAIL unsel_empty_hold: got %h want 77", rdata); end
        bus_rd(32'h8000_001C);
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL unsel_no_sticky: got %h want 0", rdata); end
    endtask

    task automatic test_counter_wrap;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        bus_rd(32'h8000_0010);
        n_checks++; if (rdata !== 32'd44) begin n_fail++; $display("FAIL cycle_wrap: got %0d want 44", rdata); end
        instr_retire = 1'b1;
        repeat (5) @(negedge clk);
        instr_retire = 1'b0;
        bus_rd(32'h8000_0014);
        n_checks++; if (rdata !== 32'd5) begin n_fail++; $display("FAIL instr_count: got %0d want 5", rdata); end
        bus_rd(32'h8000_0010);
        n_checks++; if (rdata !== 32'd51) begin n_fail++; $display("FAIL cycle_count2: got %0d want 51", rdata); end
    endtask

    task automatic test_counter_clear;
        instr_retire = 1'b1;
        bus_wr(32'h8000_0018, 32'h0);
        bus_rd(32'h8000_0010);
        n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL clr_cycle0: got %0d want 0", rdata); end
        bus_rd(32'h8000_0010);
        n_checks++; if (rdata !== 32'd1) begin n_fail++; $display("FAIL clr_cycle1: got %0d want 1", rdata); end
        bus_wr(32'h8000_0018, 32'h0);
        bus_rd(32'h8000_0014);
        n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL clr_instr0: got %0d want 0", rdata); end
        bus_rd(32'h8000_0014);
        n_checks++; if (rdata !== 32'd1) begin n_fail++; $display("FAIL clr_instr1: got %0d want 1", rdata); end
        instr_retire = 1'b0;
    endtask

    task automatic test_reset_midflight;
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) bus_wr(32'h8000_0008, 32'hC1 + 32'(i));
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hC1) begin n_fail++; $display("FAIL mid_tx_head: got %b/%h want 1/c1", tx_valid, tx_data); end
        rst = 1'b1; rx_data = 8'h99; rx_valid = 1'b1;
        @(negedge clk);
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_tx_valid: got %b want 0", tx_valid); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL mid_rst_rdata: got %h want 0", rdata); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (tx_valid !== 1'b0 || rx_ready !== 1'b0) begin n_fail++; $display("FAIL mid_first_cycle: got %b/%b want 0/0", tx_valid, rx_ready); end
        @(negedge clk);
        rx_valid = 1'b0;
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_after_tx_valid: got %b want 0", tx_valid); end
        bus_rd(32'h8000_001C);
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL mid_after_fstat: got %h want 0", rdata); end
        bus_rd(32'h8000_0000);
        n_checks++; if (rdata !== 32'h1) begin n_fail++; $display("FAIL mid_after_status: got %h want 1", rdata); end
    endtask

    initial begin
        rst = 1'b1; addr = 32'h0; wdata = 32'h0; we = 1'b0; re = 1'b0;
        instr_retire = 1'b0; rx_data = 8'h0; rx_valid = 1'b0; tx_ready = 1'b0;
        test_reset();
        test_rx_basic();
        test_rx_empty_read();
        test_tx_overflow();
        test_tx_full_push_pop();
        test_rx_full();
        test_read_write_same();
        test_unselected();
        test_counter_wrap();
        test_counter_clear();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1, "timeout");
    end
endmodule
